// File: rtl/dpmem_pkg.sv
// Shared types and helpers for the byte-writable dual-port memory.
package dpmem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int unsigned RD_LAT_MIN   = 1;
  localparam int unsigned RD_LAT_MAX   = 2;

  // Widest word the merge helper handles; callers cast to and from their own width.
  localparam int unsigned MERGE_MAX_DW = 1024;
  localparam int unsigned MERGE_MAX_BW = MERGE_MAX_DW / 8;

  // Byte-lane merge: new bytes where we is set, old bytes elsewhere.
  function automatic logic [MERGE_MAX_DW-1:0] merge(
    input logic [MERGE_MAX_DW-1:0] old_w,
    input logic [MERGE_MAX_DW-1:0] new_w,
    input logic [MERGE_MAX_BW-1:0] we
  );
    logic [MERGE_MAX_DW-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < MERGE_MAX_BW; i++) begin
      if (we[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpmem_port.sv
// Read-side pipeline for one memory port: result select, output stage(s), valid chain.
module dpmem_port
  import dpmem_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned WRITE_FIRST = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_acc,
  input  logic            i_wr,
  input  logic            i_inr,
  input  logic [DW-1:0]   i_old,
  input  logic [DW-1:0]   i_d,
  input  logic [DW/8-1:0] i_we,
  output logic [DW-1:0]   o_q,
  output logic            o_valid
);

  logic [DW-1:0] w_merged;
  logic [DW-1:0] w_res;
  logic [DW-1:0] r_q1;
  logic          r_v1;

  assign w_merged = DW'(merge(MERGE_MAX_DW'(i_old), MERGE_MAX_DW'(i_d), MERGE_MAX_BW'(i_we)));

  // Out-of-range accesses return zero; write-first returns this port's merged word.
  always_comb begin
    w_res = '0;
    if (i_inr) begin
      w_res = ((WRITE_FIRST != 0) && i_wr) ? w_merged : i_old;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= i_acc;
      if (i_acc) r_q1 <= w_res;
    end
  end

  if (RD_LAT == 2) begin : g_stage2
    logic [DW-1:0] r_q2;
    logic          r_v2;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_q2 <= '0;
        r_v2 <= 1'b0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_q2 <= r_q1;
      end
    end

    assign o_q     = r_q2;
    assign o_valid = r_v2;
  end else begin : g_stage1
    assign o_q     = r_q1;
    assign o_valid = r_v1;
  end

endmodule

// File: rtl/dpmem_bw.sv
// Dual-port RAM with byte enables, selectable read latency, init sweep,
// port-A-priority collision merge and address range checking.
module dpmem_bw
  import dpmem_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH  = 32,
  parameter int unsigned             DEPTH       = 1024,
  parameter int unsigned             RD_LAT      = 1,
  parameter int unsigned             WRITE_FIRST = 0,
  parameter logic [DATA_WIDTH-1:0]   CLEAR_VAL   = '0,
  localparam int unsigned            AW          = $clog2(DEPTH),
  localparam int unsigned            BW          = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  enb,
  input  logic [BW-1:0]         wea,
  input  logic [BW-1:0]         web,
  input  logic [AW-1:0]         addra,
  input  logic [AW-1:0]         addrb,
  input  logic [DATA_WIDTH-1:0] da,
  input  logic [DATA_WIDTH-1:0] db,
  output logic [DATA_WIDTH-1:0] qa,
  output logic [DATA_WIDTH-1:0] qb,
  output logic                  valida,
  output logic                  validb,
  output logic                  collision,
  output logic                  addr_err,
  output logic                  ready
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned CW = AW + 1;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("dpmem_bw: RD_LAT must be 1 or 2");
  end
  if ((DW % 8) != 0 || DW > MERGE_MAX_DW) begin : g_bad_width
    $error("dpmem_bw: DATA_WIDTH must be a multiple of 8 and fit the merge helper");
  end

  logic [DW-1:0] r_mem [DEPTH];

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_ready;
  logic          r_collision;
  logic          r_addr_err;

  logic          w_acc_a;
  logic          w_acc_b;
  logic          w_is_wr_a;
  logic          w_is_wr_b;
  logic          w_inr_a;
  logic          w_inr_b;
  logic          w_same;
  logic          w_wr_a;
  logic          w_wr_b;
  logic          w_wr_b_eff;
  logic [DW-1:0] w_old_a;
  logic [DW-1:0] w_old_b;
  logic [DW-1:0] w_base_a;
  logic [DW-1:0] w_wdata_a;
  logic [DW-1:0] w_wdata_b;

  // Clear sweep FSM: one word per cycle, then stay in RUN until reset.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(DEPTH - 1)) w_state_nxt = ST_RUN;
      end
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == ST_RUN);
    end
  end

  assign w_acc_a   = ena && r_ready;
  assign w_acc_b   = enb && r_ready;
  assign w_is_wr_a = |wea;
  assign w_is_wr_b = |web;
  assign w_inr_a   = {1'b0, addra} < CW'(DEPTH);
  assign w_inr_b   = {1'b0, addrb} < CW'(DEPTH);
  assign w_same    = (addra == addrb);
  assign w_wr_a    = w_acc_a && w_is_wr_a && w_inr_a;
  assign w_wr_b    = w_acc_b && w_is_wr_b && w_inr_b;

  assign w_old_a   = w_inr_a ? r_mem[addra] : '0;
  assign w_old_b   = w_inr_b ? r_mem[addrb] : '0;

  // Same-address double write: B's bytes go under A's, so A wins shared lanes.
  assign w_base_a   = (w_wr_b && w_same)
                    ? DW'(merge(MERGE_MAX_DW'(w_old_a), MERGE_MAX_DW'(db), MERGE_MAX_BW'(web)))
                    : w_old_a;
  assign w_wdata_a  = DW'(merge(MERGE_MAX_DW'(w_base_a), MERGE_MAX_DW'(da), MERGE_MAX_BW'(wea)));
  assign w_wdata_b  = DW'(merge(MERGE_MAX_DW'(w_old_b), MERGE_MAX_DW'(db), MERGE_MAX_BW'(web)));
  assign w_wr_b_eff = w_wr_b && !(w_wr_a && w_same);

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_cnt[AW-1:0]] <= CLEAR_VAL;
      end else begin
        if (w_wr_a)     r_mem[addra] <= w_wdata_a;
        if (w_wr_b_eff) r_mem[addrb] <= w_wdata_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_collision <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_collision <= w_acc_a && w_acc_b && w_same && (w_is_wr_a || w_is_wr_b);
      r_addr_err  <= (w_acc_a && !w_inr_a) || (w_acc_b && !w_inr_b);
    end
  end

  dpmem_port #(
    .DW          (DW),
    .RD_LAT      (RD_LAT),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_port_a (
    .clk     (clk),
    .reset   (reset),
    .i_acc   (w_acc_a),
    .i_wr    (w_is_wr_a),
    .i_inr   (w_inr_a),
    .i_old   (w_old_a),
    .i_d     (da),
    .i_we    (wea),
    .o_q     (qa),
    .o_valid (valida)
  );

  dpmem_port #(
    .DW          (DW),
    .RD_LAT      (RD_LAT),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_port_b (
    .clk     (clk),
    .reset   (reset),
    .i_acc   (w_acc_b),
    .i_wr    (w_is_wr_b),
    .i_inr   (w_inr_b),
    .i_old   (w_old_b),
    .i_d     (db),
    .i_we    (web),
    .o_q     (qb),
    .o_valid (validb)
  );

  assign collision = r_collision;
  assign addr_err  = r_addr_err;
  assign ready     = r_ready;

endmodule
